sinx_req_arbiter: RTL and testbench

Shares one floating-point CORDIC sine core (SinX) between NREQ requesters. The block runs round-robin arbitration and latches the winning angle. It drives the core's start pulse and holds its input stable for the whole computation. It returns the core result tagged with the requester ID, and recovers the core with a reset pulse if it does not finish within a timeout.

---
 rtl/sinx_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_sinx_req_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sinx_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sinx_req_arbiter
// Brief    : Round-robin arbiter sharing one SinX CORDIC core among NREQ
//            requesters, with ID-tagged responses and hung-core recovery.
// Revision : 1.0 - initial release
// ============================================================================
module sinx_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1023,
    parameter int CNTW    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_angle,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_data,
    output logic               rsp_err,
    output logic               core_start,
    output logic [31:0]        core_in,
    output logic               core_rst,
    input  logic [31:0]        core_out,
    input  logic               core_oe
);

    localparam logic [2:0]      c_idle     = 3'd0;
    localparam logic [2:0]      c_start    = 3'd1;
    localparam logic [2:0]      c_wait     = 3'd2;
    localparam logic [2:0]      c_resp     = 3'd3;
    localparam logic [2:0]      c_recover  = 3'd4;
    localparam logic [CNTW-1:0] c_cnt_last = CNTW'(TIMEOUT - 1);
    localparam logic [IDW-1:0]  c_id_last  = IDW'(NREQ - 1);

    logic [2:0]      r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [CNTW-1:0] r_cnt;
    logic [31:0]     r_ang;
    logic [IDW-1:0]  r_id;
    logic [31:0]     r_rsp_data;
    logic            r_rsp_err;
    logic            r_core_start;

    logic [2:0]      w_state_nxt;
    logic            w_any;
    logic            w_hi_any;
    logic [IDW-1:0]  w_hi;
    logic [IDW-1:0]  w_lo;
    logic [IDW-1:0]  w_grant;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [31:0]     w_ang;

    // Round-robin pick: lowest valid index at or above the pointer, else the
    // lowest valid index overall (the wrap-around case).
    always_comb begin
        w_any    = |req_valid;
        w_hi_any = 1'b0;
        w_hi     = '0;
        w_lo     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo = IDW'(i);
                if (IDW'(i) >= r_rr_ptr) begin
                    w_hi     = IDW'(i);
                    w_hi_any = 1'b1;
                end
            end
        end
        w_grant   = w_hi_any ? w_hi : w_lo;
        w_ptr_nxt = (w_grant == c_id_last) ? '0 : w_grant + IDW'(1);
    end

    always_comb begin
        w_ang     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_ang        = req_angle[32*i +: 32];
                req_ready[i] = (r_state == c_idle) && !reset && w_any;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:    if (w_any) w_state_nxt = c_start;
            c_start:   w_state_nxt = c_wait;
            c_wait:    if (core_oe || (r_cnt == c_cnt_last)) w_state_nxt = c_resp;
            c_resp:    if (rsp_ready) w_state_nxt = r_rsp_err ? c_recover : c_idle;
            c_recover: w_state_nxt = c_idle;
            default:   w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_idle;
            r_rr_ptr     <= '0;
            r_cnt        <= '0;
            r_ang        <= '0;
            r_id         <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_core_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_core_start <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_any) begin
                        r_ang        <= w_ang;
                        r_id         <= w_grant;
                        r_rr_ptr     <= w_ptr_nxt;
                        r_core_start <= 1'b1;
                    end
                end
                c_start: r_cnt <= '0;
                c_wait: begin
                    r_cnt <= r_cnt + CNTW'(1);
                    // A done strobe on the last counted cycle still wins.
                    if (core_oe) begin
                        r_rsp_data <= core_out;
                        r_rsp_err  <= 1'b0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // r_ang only changes on a grant in IDLE, so the core input is frozen while busy.
    assign core_in    = r_ang;
    assign core_start = r_core_start;
    assign core_rst   = reset || (r_state == c_recover);
    assign rsp_valid  = (r_state == c_resp);
    assign rsp_id     = r_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_sinx_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sinx_req_arbiter
// Brief    : Randomized self-checking bench for sinx_req_arbiter with a
//            behavioural core model and round-robin reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sinx_req_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 40;
    localparam int CNTW    = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_angle;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_data;
    logic               rsp_err;
    logic               core_start;
    logic [31:0]        core_in;
    logic               core_rst;
    logic [31:0]        core_out;
    logic               core_oe;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_ptr   = 0;
    int cd       = 0;
    bit arm      = 1'b0;

    sinx_req_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_angle(req_angle),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_start(core_start), .core_in(core_in), .core_rst(core_rst),
        .core_out(core_out), .core_oe(core_oe)
    );

    always #5 clk = ~clk;

    // Stand-in for the sine core: 30 degrees maps to 0.5, anything else to a
    // reversible scramble so each angle yields a distinct result.
    function automatic logic [31:0] sinx(input logic [31:0] a);
        if (a == 32'h41F0_0000) return 32'h3F00_0000;
        return {a[15:0], a[31:16]} ^ 32'h3F00_0000;
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (tb_ptr + k) % NREQ;
            if (m[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        core_oe  = 1'b0;
        core_out = $urandom;
        if (arm) begin
            cd--;
            if (cd == 0) begin
                core_oe  = 1'b1;
                core_out = sinx(core_in);
                arm      = 1'b0;
            end
        end
    endtask

    // lat: cycles in WAIT before core_oe (<=0 means the core never answers)
    task automatic txn(input logic [NREQ-1:0] mask, input int lat, input int hold, input bit fixed);
        int          g;
        int          exp_wait;
        logic        exp_err;
        logic [31:0] ang;
        logic [31:0] exp_data;
        for (int i = 0; i < NREQ; i++) req_angle[32*i +: 32] = $urandom;
        if (fixed) req_angle[31:0] = 32'h41F0_0000;
        req_valid = mask;
        g = exp_grant(mask);
        ang = req_angle[32*g +: 32];
        #1;
        check("req_ready_grant", 32'(req_ready), 32'(1) << g);
        tick();
        tb_ptr = (g + 1) % NREQ;
        check("core_start_pulse", 32'(core_start), 32'd1);
        check("core_in_start", core_in, ang);
        check("req_ready_start", 32'(req_ready), 32'd0);
        exp_err  = !(lat >= 1 && lat <= TIMEOUT);
        exp_wait = exp_err ? TIMEOUT : lat;
        exp_data = exp_err ? 32'd0 : sinx(ang);
        if (!exp_err) begin
            cd  = lat;
            arm = 1'b1;
        end
        for (int k = 0; k < exp_wait; k++) begin
            tick();
            check("wait_no_rsp", 32'(rsp_valid), 32'd0);
            check("wait_start_low", 32'(core_start), 32'd0);
            check("wait_core_in", core_in, ang);
            check("wait_ready_low", 32'(req_ready), 32'd0);
        end
        tick();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_id", 32'(rsp_id), 32'(g));
            check("hold_data", rsp_data, exp_data);
            check("hold_ready_low", 32'(req_ready), 32'd0);
            check("hold_core_in", core_in, ang);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("core_rst_recover", 32'(core_rst), 32'(exp_err));
        if (exp_err) begin
            check("recover_ready_low", 32'(req_ready), 32'd0);
            tick();
            check("core_rst_release", 32'(core_rst), 32'd0);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_core_in", core_in, 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_angle = '0;
        rsp_ready = 1'b0;
        core_oe   = 1'b0;
        core_out  = '0;
        tick();
        tick();
        check_reset_vals();
        reset = 1'b0;
        tick();
        check("core_rst_idle", 32'(core_rst), 32'd0);

        txn(4'b0001, 50, 0, 1'b1);
        for (int n = 0; n < 5; n++) txn(4'hF, 2 + $urandom_range(0, 6), 0, 1'b0);
        txn(4'b0010, 5, 20, 1'b0);
        txn(4'b1000, 0, 2, 1'b0);
        txn(4'b0001, TIMEOUT, 0, 1'b0);
        txn(4'b0101, TIMEOUT - 1, 1, 1'b0);

        req_valid = '0;
        tick();
        core_oe  = 1'b1;
        core_out = 32'hDEAD_BEEF;
        tick();
        check("spurious_no_rsp", 32'(rsp_valid), 32'd0);
        check("spurious_no_start", 32'(core_start), 32'd0);
        tick();
        check("spurious_still_idle", 32'(rsp_valid), 32'd0);

        for (int n = 0; n < 20; n++) begin
            int sel;
            int lat;
            sel = $urandom_range(0, 9);
            lat = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT : 1 + $urandom_range(0, 11);
            txn(NREQ'($urandom_range(1, 15)), lat, $urandom_range(0, 3), 1'b0);
        end

        // Reset while the core is busy, then confirm the pointer restarts at 0.
        req_valid = 4'b0100;
        tick();
        tb_ptr = 3;
        check("mid_start", 32'(core_start), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        arm   = 1'b0;
        tick();
        check_reset_vals();
        reset     = 1'b0;
        req_valid = '0;
        tb_ptr    = 0;
        tick();
        check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        txn(4'hF, 4, 0, 1'b0);
        txn(4'hF, 3, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
